// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: serializer state encodings and UART MMIO address map
package uart_tx_mmio_pkg;
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'h8000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;
  localparam logic [31:0] UART_RX_ADDR     = 32'h8000_000C;
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU-side write strobe/data and transmitter status
interface uart_tx_mmio_if;
  logic       we;
  logic [7:0] din;
  logic       tx_ready;
  logic       tx_busy;
  logic       overflow;
  logic       serial_out;
  modport master (output we, din, input tx_ready, tx_busy, overflow, serial_out);
  modport slave  (input we, din, output tx_ready, tx_busy, overflow, serial_out);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full    = count_q == (AW+1)'(DEPTH);
    empty   = count_q == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    rdata   = mem[rptr_q];
    count   = count_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr_q] <= wdata;
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: queued 8N1 UART transmitter behind the MIPS150 UART write port
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_mmio_if.slave bus
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  tx_state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic overflow_q, overflow_d;
  logic tick, pop, full, empty;
  logic [AW:0] count;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(bus.we), .pop(pop), .wdata(bus.din),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  // a pop in STOP chains straight into the next START with no idle bit
  always_comb begin
    tick       = baud_q == CW'(CPB - 1);
    pop        = !empty && (state_q == ST_IDLE || (state_q == ST_STOP && tick));
    baud_d     = (state_q == ST_IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d      = state_q == ST_DATA ? bit_q + {2'b0, tick} : '0;
    shift_d    = pop ? head : (state_q == ST_DATA && tick) ? shift_q >> 1 : shift_q;
    overflow_d = overflow_q || (bus.we && full);
    state_d    = pop ? ST_START :
                 (state_q == ST_IDLE || !tick) ? state_q :
                 state_q == ST_START ? ST_DATA :
                 state_q == ST_DATA ? (bit_q == 3'd7 ? ST_STOP : ST_DATA) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  assign bus.serial_out = state_q == ST_START ? 1'b0 : state_q == ST_DATA ? shift_q[0] : 1'b1;
  assign bus.tx_ready   = !full;
  assign bus.tx_busy    = state_q != ST_IDLE || count != '0;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed writes feed an expected-byte queue; a line monitor decodes frames and compares
module tb_uart_tx_mmio;
  logic clk = 0;
  logic reset = 1;
  int passed = 0, total = 0, frames = 0;
  logic [7:0] exp_q[$];
  uart_tx_mmio_if bus();
  uart_tx_mmio #(.CLOCK_FREQ(16), .BAUD_RATE(2), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
  endtask
  function automatic logic [3:0] st();
    return {bus.serial_out, bus.tx_ready, bus.tx_busy, bus.overflow};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    bus.we = 1;
    bus.din = d;
    tick();
    bus.we = 0;
  endtask
  task automatic wait_idle(input string n);
    for (int i = 0; i < 1000 && bus.tx_busy; i++) tick();
    chk(n, bus.tx_busy, 0);
  endtask
  task automatic rx_frame();
    logic [9:0] bits;
    logic ok;
    ok = 1;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 8; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (reset) return;
        if (c == 0) bits[b] = bus.serial_out;
        else if (bus.serial_out !== bits[b]) ok = 0;
      end
    frames++;
    chk("bit_width", ok, 1);
    chk("start_stop", {bits[9], bits[0]}, 2'b10);
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL frame_data: got %0h expected none", bits[8:1]);
    end else chk("frame_data", bits[8:1], exp_q.pop_front());
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset && bus.serial_out === 1'b0) rx_frame();
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic bad;
    bus.we = 0;
    bus.din = 0;
    #1 chk("reset_status", st(), 4'b1100);
    tick(2);
    reset = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (st() !== 4'b1100) bad = 1; end
    chk("idle_50", bad, 0);
    exp_q.push_back(8'h55);
    wr(8'h55);
    chk("t2_queued", st(), 4'b1110);
    tick();
    chk("t2_start_fall", bus.serial_out, 0);
    tick(79);
    chk("t2_last_cycle", st(), 4'b1110);
    tick();
    chk("t2_busy_drop", st(), 4'b1100);
    tick(5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wr(8'hA5);
    wr(8'h3C);
    tick(79);
    chk("t3_stop_bit", bus.serial_out, 1);
    tick();
    chk("t3_no_gap", {bus.serial_out, bus.tx_busy}, 2'b01);
    wait_idle("t3_idle");
    tick(5);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    chk("t4_ready_count3", {bus.tx_ready, bus.overflow}, 2'b10);
    wr(8'h05);
    chk("t4_full", {bus.tx_ready, bus.overflow}, 2'b00);
    wr(8'h06);
    chk("t4_drop_full", {bus.tx_ready, bus.overflow}, 2'b01);
    tick(75);
    chk("t4_still_full", bus.tx_ready, 0);
    wr(8'h07);
    chk("t4_drop_same_edge_pop", {bus.tx_ready, bus.overflow}, 2'b11);
    exp_q.push_back(8'h08);
    wr(8'h08);
    chk("t4_refill", {bus.tx_ready, bus.overflow}, 2'b01);
    wait_idle("t4_idle");
    chk("t4_overflow_sticky", bus.overflow, 1);
    tick(5);
    wr(8'hFF);
    tick(30);
    reset = 1;
    #1 chk("t5_reset_mid_frame", st(), 4'b1100);
    tick();
    reset = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (st() !== 4'b1100) bad = 1; end
    chk("t5_quiet_after_reset", bad, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin bus.din = 8'(i * 37 + 1); tick(); if (st() !== 4'b1100) bad = 1; end
    chk("t6_we_low", bad, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_count", frames, 9);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
